// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core: instruction field layout,
// opcode values, control FSM state encoding and a decode helper.
package core_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FIELD_W = 4;

  // Instruction field positions: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb/imm4
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_LSB = 8;
  localparam int unsigned RA_LSB = 4;
  localparam int unsigned RB_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BLE  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  // Opcodes 0..7 (ALU ops, ADDI, LW) produce a register result
  function automatic logic writes_rd(input logic [3:0] op);
    return (op <= OP_LW);
  endfunction

endpackage

// File: rtl/core_regfile.sv
// 16 x DATA_W register file: one write port, two read ports and a debug
// read port. r0 is never written, so it always reads zero.
// Ports: clk, rst (async, active-high), we/waddr/wdata write port,
//        raddr_a/rdata_a, raddr_b/rdata_b read ports, dbg_addr/dbg_data.
module core_regfile #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [3:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [16];

  // Write port; writes to r0 are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we && (waddr != 4'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/core_mc_top.sv
// Multi-cycle processor core: control FSM, ALU and register file fetching
// and executing from external memory over a req/ready handshake with any
// number of wait states. Adds HALT, halted/pc status and a debug reg port.
// Optional feature macro: CORE_STEP_EN adds a 'step' input that runs a
// single instruction from IDLE while run_n=1.
// Ports: clk, rst (async, active-high), run_n, [step], dbg_reg_addr/dbg_reg_out,
//        mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready, halted, pc_out.
module core_mc_top
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_n,
`ifdef CORE_STEP_EN
  input  logic              step,
`endif
  input  logic [3:0]        dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  state_t              state, state_next;
  logic [INSTR_W-1:0]  ir, ir_next;
  logic [DATA_W-1:0]   res, res_next;
  logic                taken, taken_next;
  logic [ADDR_W-1:0]   pc, pc_next;
  logic                req_next, we_next, halted_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [DATA_W-1:0]   wdata_next;
  logic                start;

  logic [3:0] op, rd, ra, rb;
  logic [DATA_W-1:0] a_val, b_val, imm, sum_ai, alu_res;
  logic [ADDR_W-1:0] ea, pc_inc, br_tgt;
  logic              le;

  assign op = ir[OP_LSB +: FIELD_W];
  assign rd = ir[RD_LSB +: FIELD_W];
  assign ra = ir[RA_LSB +: FIELD_W];
  assign rb = ir[RB_LSB +: FIELD_W];

`ifdef CORE_STEP_EN
  assign start = !run_n || step;
`else
  assign start = !run_n;
`endif

  // Port b reads rd for SW so the store data is available in EXEC
  core_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       ((state == ST_WB) && writes_rd(op)),
    .waddr    (rd),
    .wdata    (res),
    .raddr_a  (ra),
    .rdata_a  (a_val),
    .raddr_b  ((op == OP_SW) ? rd : rb),
    .rdata_b  (b_val),
    .dbg_addr (dbg_reg_addr),
    .dbg_data (dbg_reg_out)
  );

  assign imm    = {{(DATA_W-FIELD_W){rb[3]}}, rb};
  assign sum_ai = a_val + imm;
  assign ea     = sum_ai[ADDR_W-1:0];
  assign le     = ($signed(a_val) <= $signed(b_val));
  assign pc_inc = pc + ADDR_W'(1);
  assign br_tgt = pc_inc + {{(ADDR_W-FIELD_W){rd[3]}}, rd};
  assign pc_out = pc;

  // ALU
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_val + b_val;
      OP_SUB:  alu_res = a_val - b_val;
      OP_AND:  alu_res = a_val & b_val;
      OP_OR:   alu_res = a_val | b_val;
      OP_XOR:  alu_res = a_val ^ b_val;
      OP_SLL:  alu_res = a_val << b_val[3:0];
      OP_ADDI: alu_res = sum_ai;
      default: alu_res = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_next = state;
    ir_next    = ir;
    res_next   = res;
    taken_next = taken;
    pc_next    = pc;
    req_next   = 1'b0;
    we_next    = 1'b0;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          req_next   = 1'b1;
          addr_next  = pc;
        end
      end
      ST_FETCH: begin
        req_next = 1'b1;
        if (mem_ready) begin
          ir_next    = mem_rdata[INSTR_W-1:0];
          req_next   = 1'b0;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_next   = alu_res;
        taken_next = (op == OP_BLE) && le;
        if ((op == OP_LW) || (op == OP_SW)) begin
          state_next = ST_MEM;
          req_next   = 1'b1;
          we_next    = (op == OP_SW);
          addr_next  = ea;
          wdata_next = b_val;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        req_next = 1'b1;
        we_next  = mem_we;
        if (mem_ready) begin
          req_next = 1'b0;
          we_next  = 1'b0;
          if (op == OP_LW) res_next = mem_rdata;
          state_next = ST_WB;
        end
      end
      ST_WB: begin
        pc_next = taken ? br_tgt : pc_inc;
        if (op == OP_HALT) begin
          state_next = ST_HALT;
        end else if (!run_n) begin
          state_next = ST_FETCH;
          req_next   = 1'b1;
          addr_next  = pc_next;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
    halted_next = (state_next == ST_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ir        <= '0;
      res       <= '0;
      taken     <= 1'b0;
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      ir        <= ir_next;
      res       <= res_next;
      taken     <= taken_next;
      pc        <= pc_next;
      mem_req   <= req_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      halted    <= halted_next;
    end
  end

endmodule

// File: tb/tb_core_mc_top.sv
// Testbench for core_mc_top: an ISA-level reference model predicts every
// bus transaction and the final architectural state; a memory responder
// with random wait states serves the core, and a monitor pops and compares
// each accepted transaction against the scoreboard queue.
module tb_core_mc_top;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_n = 1'b1;
`ifdef CORE_STEP_EN
  logic          step = 1'b0;
`endif
  logic [3:0]    dbg_reg_addr = '0;
  logic [DW-1:0] dbg_reg_out;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          halted;
  logic [AW-1:0] pc_out;

  core_mc_top #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(8'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .run_n        (run_n),
`ifdef CORE_STEP_EN
    .step         (step),
`endif
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_out  (dbg_reg_out),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .halted       (halted),
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            fetch;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
  } xact_t;

  xact_t         exp_q[$];
  logic [DW-1:0] prog    [DEPTH];
  logic [DW-1:0] tb_mem  [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_regs[16];
  logic [AW-1:0] ref_pc;

  int n_chk = 0, n_pass = 0;
  int wmin = 0, wmax = 0;
  bit spur = 0, zw = 0;
  int cyc = 0, last_fetch = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction-set model: runs the program, queues every expected bus
  // transaction and the cycle count each instruction takes with zero wait.
  task automatic model_run(output bit ok);
    logic [15:0]   ins;
    logic [3:0]    op, rd, ra, rb;
    logic [DW-1:0] a, b, val;
    logic [AW-1:0] ea, nxt;
    int immi, offs, lat, prev_lat;
    bit wr;
    ok = 0;
    prev_lat = 0;
    ref_pc = '0;
    exp_q.delete();
    for (int r = 0; r < 16; r++) ref_regs[r] = '0;
    for (int n = 0; n < 200 && !ok; n++) begin
      ins = ref_mem[ref_pc][15:0];
      {op, rd, ra, rb} = ins;
      exp_q.push_back('{1'b1, 1'b0, ref_pc, '0, prev_lat});
      a    = ref_regs[ra];
      b    = ref_regs[rb];
      immi = (rb >= 4'd8) ? int'(rb) - 16 : int'(rb);
      offs = (rd >= 4'd8) ? int'(rd) - 16 : int'(rd);
      ea   = AW'(a + DW'(immi));
      nxt  = AW'(int'(ref_pc) + 1);
      lat  = 3;
      wr   = 1;
      val  = '0;
      case (op)
        4'h0: val = a + b;
        4'h1: val = a - b;
        4'h2: val = a & b;
        4'h3: val = a | b;
        4'h4: val = a ^ b;
        4'h5: val = a << b[3:0];
        4'h6: val = a + DW'(immi);
        4'h7: begin
          val = ref_mem[ea];
          lat = 4;
          exp_q.push_back('{1'b0, 1'b0, ea, '0, 0});
        end
        4'h8: begin
          wr = 0;
          lat = 4;
          exp_q.push_back('{1'b0, 1'b1, ea, ref_regs[rd], 0});
          ref_mem[ea] = ref_regs[rd];
        end
        4'h9: begin
          wr = 0;
          if ($signed(a) <= $signed(b)) nxt = AW'(int'(ref_pc) + 1 + offs);
        end
        4'hF: begin
          wr = 0;
          ok = 1;
        end
        default: wr = 0;
      endcase
      if (wr && rd != 4'd0) ref_regs[rd] = val;
      ref_pc = nxt;
      prev_lat = lat;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: random wait states, optional spurious ready when idle
  bit            pend = 0;
  int            wcnt = 0;
  logic [AW-1:0] l_addr;
  logic          l_we;
  logic [DW-1:0] l_wd;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_ready = 1'b0;
      pend = 0;
    end else if (mem_req) begin
      if (!pend) begin
        pend   = 1;
        wcnt   = $urandom_range(wmax, wmin);
        l_addr = mem_addr;
        l_we   = mem_we;
        l_wd   = mem_wdata;
      end else begin
        check("req_stable", {mem_we, mem_addr, mem_wdata}, {l_we, l_addr, l_wd});
      end
      if (wcnt == 0) begin
        mem_ready = 1'b1;
        mem_rdata = tb_mem[mem_addr];
        if (mem_we) tb_mem[mem_addr] = mem_wdata;
        pend = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = DW'($urandom);
        wcnt--;
      end
    end else begin
      mem_ready = spur && ($urandom_range(3, 0) == 0);
      mem_rdata = DW'($urandom);
      pend = 0;
    end
  end

  // Monitor: every accepted transaction is popped and compared
  always @(negedge clk) begin
    xact_t e;
    if (!rst && mem_req && mem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xact", {mem_we, mem_addr}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check(e.fetch ? "fetch_addr" : "data_addr", mem_addr, e.addr);
        check("xact_we", mem_we, e.we);
        if (e.we) check("store_data", mem_wdata, e.wdata);
        if (e.fetch) begin
          if (zw && e.lat != 0) check("instr_cycles", cyc - last_fetch, e.lat);
          last_fetch = cyc;
        end
      end
    end
  end

  task automatic start_prog();
    bit ok;
    rst = 1'b1;
    run_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = prog[i];
      ref_mem[i] = prog[i];
    end
    model_run(ok);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc_out, 0);
    check("rst_mem_addr", mem_addr, 0);
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic wait_req(input logic [AW-1:0] a, input bit we);
    int n = 0;
    while (!(mem_req && mem_addr == a && mem_we == we) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", mem_req && mem_addr == a && mem_we == we, 1);
  endtask

  task automatic dbg_check(input string name, input int r, input logic [DW-1:0] exp);
    dbg_reg_addr = 4'(r);
    #1;
    check(name, dbg_reg_out, exp);
  endtask

  task automatic final_check();
    int bad = 0;
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    for (int r = 0; r < 16; r++) dbg_check($sformatf("reg_r%0d", r), r, ref_regs[r]);
    check("final_pc", pc_out, ref_pc);
    check("halt_no_req", mem_req, 0);
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    check("mem_image_diffs", bad, 0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
  endtask

  task automatic run_full();
    start_prog();
    run_n = 1'b0;
    wait_halt();
    final_check();
  endtask

  initial begin
    // ADDI chain, zero-wait with cycle counts
    clear_prog();
    prog[0] = 16'h6105; prog[1] = 16'h621D; prog[2] = 16'hF000;
    zw = 1; wmin = 0; wmax = 0; spur = 0;
    run_full();
    dbg_check("addi_r1", 1, 16'd5);
    dbg_check("addi_r2", 2, 16'd2);
    check("addi_pc", pc_out, 3);
    check("addi_halted", halted, 1);

    // Same program with 0-4 wait states and spurious ready
    zw = 0; wmax = 4; spur = 1;
    run_full();
    dbg_check("wait_r2", 2, 16'd2);

    // SW then LW through address 4
    clear_prog();
    prog[0] = 16'h6105; prog[1] = 16'h8104; prog[2] = 16'h7304; prog[3] = 16'hF000;
    zw = 1; wmax = 0; spur = 0;
    run_full();
    check("sw_mem4", tb_mem[4], 16'd5);
    dbg_check("lw_r3", 3, 16'd5);

    // BLE taken with offset -2 at pc 0: target wraps to 255
    clear_prog();
    prog[0] = 16'h9E00; prog[255] = 16'hF000;
    run_full();
    check("ble_wrap_pc", pc_out, 0);

    // BLE taken (0<=5) and not taken (5<=0)
    clear_prog();
    prog[0] = 16'h6105; prog[1] = 16'h9101; prog[2] = 16'h6207;
    prog[3] = 16'h9210; prog[4] = 16'h6201; prog[5] = 16'hF000;
    run_full();
    dbg_check("ble_r2", 2, 16'd1);
    check("ble_pc", pc_out, 6);

    // Wrap-around arithmetic
    clear_prog();
    prog[0] = 16'h6101; prog[1] = 16'h620F; prog[2] = 16'h5312;
    prog[3] = 16'h0433; prog[4] = 16'h1501; prog[5] = 16'hF000;
    wmax = 2; spur = 1; zw = 0;
    run_full();
    dbg_check("sll_r3", 3, 16'h8000);
    dbg_check("add_ovf_r4", 4, 16'h0000);
    dbg_check("sub_wrap_r5", 5, 16'hFFFF);

    // run_n=1 while LW waits in MEM: completes, idles, then resumes
    clear_prog();
    prog[0] = 16'h6107; prog[1] = 16'h7211; prog[2] = 16'h6321; prog[3] = 16'hF000;
    prog[8] = DW'($urandom);
    wmin = 3; wmax = 3; spur = 0;
    start_prog();
    run_n = 1'b0;
    wait_req(8'd8, 1'b0);
    run_n = 1'b1;
    repeat (20) @(negedge clk);
    check("pause_pc", pc_out, 2);
    check("pause_no_req", mem_req, 0);
    check("pause_not_halted", halted, 0);
    check("pause_queue", exp_q.size(), 2);
    dbg_check("pause_lw_r2", 2, prog[8]);
    run_n = 1'b0;
    wait_halt();
    final_check();

    // Reset while a fetch is waiting
    clear_prog();
    prog[0] = 16'h6105; prog[1] = 16'h8109; prog[2] = 16'h6201; prog[3] = 16'hF000;
    wmin = 4; wmax = 4;
    start_prog();
    run_n = 1'b0;
    wait_req(8'd2, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_mem_we", mem_we, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_halted", halted, 0);
    check("arst_pc", pc_out, 0);
    dbg_check("arst_r1", 1, 16'd0);
    exp_q.delete();
    @(negedge clk);
    wmin = 0; wmax = 0;
    run_full();

`ifdef CORE_STEP_EN
    // Single-step three instructions from IDLE
    clear_prog();
    prog[0] = 16'h6101; prog[1] = 16'h6202; prog[2] = 16'h6303; prog[3] = 16'hF000;
    start_prog();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (10) @(negedge clk);
      check("step_pc", pc_out, k + 1);
      check("step_idle_no_req", mem_req, 0);
    end
    dbg_check("step_r3", 3, 16'd3);
    exp_q.delete();
`endif

    // Random programs
    for (int it = 0; it < 10; it++) begin
      bit ok;
      ok = 0;
      while (!ok) begin
        for (int i = 0; i < DEPTH; i++) prog[i] = DW'($urandom);
        prog[24] = 16'hF000;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = prog[i];
        model_run(ok);
      end
      zw   = (it < 3);
      wmin = 0;
      wmax = (it < 3) ? 0 : 4;
      spur = (it >= 3);
      run_full();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
